program_sequencer: RTL and testbench
====================================

# program_sequencer

Instruction-issue stage directly upstream of the bit-serial core. Holds a small loadable program of 3-bit instructions and a program counter. It drives one instruction at a time plus a one-cycle start strobe into the core, then advances when the core's PC-increment strobe returns. It also adds single-step, halt-at-boundary and a watchdog for a core that never completes.

## Interface
Parameters:
- `DEPTH`, 16: program memory words; power of two, at least 2.
- `AW`, $clog2(DEPTH): address width.
- `TIMEOUT_CYC`, 64: maximum cycles in WAIT before an error is flagged; at least 2.

Ports:
- `i_clk` in 1: single clock; everything is rising-edge.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_load_we` in 1: program write strobe; honoured only in IDLE.
- `i_load_addr` in AW: write address.
- `i_load_data` in 3: instruction word to write.
- `i_last_addr` in AW: address of the final instruction; sampled at each boundary.
- `i_run` in 1: start the program from address 0; honoured only in IDLE.
- `i_step_mode` in 1: when 1, pause after every instruction.
- `i_step` in 1: release one instruction from PAUSE.
- `i_halt` in 1: request a stop at the next instruction boundary.
- `i_con_pcincr` in 1: core completion strobe.
- `o_instr` out 3: instruction to the core (the core's i_data_instruction).
- `o_start` out 1: one-cycle issue strobe (the core's i_start).
- `o_pc` out AW: address of `o_instr`.
- `o_busy` out 1: high in every state except IDLE.
- `o_done` out 1: one-cycle pulse after the last instruction completes.
- `o_err` out 1: sticky watchdog error; cleared by `i_run` or reset.

## Operation
- States: IDLE, ISSUE, WAIT, PAUSE.
- **IDLE**
  - `i_load_we` writes `mem[i_load_addr]`.
  - `i_run` sets pc to 0, clears `o_err` and the halt flag, then goes to ISSUE.
  - If `i_run` and `i_load_we` arrive in the same cycle, the write happens and then the run starts.
- **ISSUE**
  - `o_start`=1 for exactly this cycle.
  - `o_instr` is registered from `mem[pc]` on entry.
  - Next state is WAIT unconditionally.
- **WAIT**
  - The watchdog counter increments each cycle.
  - On `i_con_pcincr`:
    - If pc == `i_last_addr`: pulse `o_done` and go to IDLE; pc holds.
    - Otherwise, if the halt flag is set: pc+1, go to IDLE, no `o_done`.
    - Otherwise pc+1, then go to PAUSE if `i_step_mode`, else ISSUE.
  - If the counter reaches `TIMEOUT_CYC` without `i_con_pcincr`: set `o_err` and go to IDLE.
- **PAUSE**
  - `i_step` goes to ISSUE.
  - `i_halt` goes to IDLE.
- `i_halt` in ISSUE or WAIT sets a flag that is consumed at the next WAIT exit.
- Strobes ignored outside their stated states:
  - `i_con_pcincr` outside WAIT.
  - `i_run` while busy.
  - `i_step` outside PAUSE.
  - `i_load_we` while busy.
- pc wraps modulo DEPTH if `i_last_addr` is never matched (pc = DEPTH-1 advances to 0).
- `o_instr` and `o_pc` stay stable from ISSUE until the next ISSUE.

## Timing
- Reset values:
  - State IDLE, pc 0, watchdog 0, halt flag 0.
  - `o_instr` 0, `o_start` 0, `o_busy` 0, `o_done` 0, `o_err` 0.
  - Memory contents are not reset.
- `i_run` at cycle n: ISSUE and `o_start`=1 at n+1, WAIT from n+2.
- `i_con_pcincr` at cycle m: next ISSUE at m+1, so the core sees a start one cycle after its increment.
- `o_done` and the entry to IDLE both occur at m+1.
- The watchdog clears on each ISSUE. Timeout fires on the WAIT cycle whose count equals `TIMEOUT_CYC`. If `i_con_pcincr` arrives in that same cycle, completion wins.
- Reset mid-operation returns to IDLE the next cycle, with no `o_done`.

## Structure
- Package `bit_serial_pkg` holds:
  - `INSTR_W` = 3.
  - Enum `seq_state_t` {IDLE, ISSUE, WAIT, PAUSE}.
  - Default `DEPTH` and `TIMEOUT_CYC` constants.
- Sub-module `instr_mem`: DEPTH x INSTR_W, synchronous write, combinational read. The sequencer registers the read into `o_instr`.

## Test plan
- **Normal run.** Load `mem[0..2]` = 3'b001, 3'b100, 3'b010; `i_last_addr`=2; pulse `i_run`; core model returns `i_con_pcincr` 8 cycles after each `o_start`.
  - Expect three `o_start` pulses 9 cycles apart, carrying 1, 4, 2 with `o_pc` 0, 1, 2.
  - Expect `o_done` one cycle after the third `i_con_pcincr`, and `o_busy` low on that same cycle.
- **Single step.** `i_step_mode`=1, same program.
  - After the first `i_con_pcincr` the block sits in PAUSE with `o_pc`=1 and no `o_start` for 20 cycles.
  - Pulse `i_step`: `o_start` follows one cycle later with `o_instr`=4.
- **Halt at boundary.** Assert `i_halt` 3 cycles after the first `o_start`.
  - After that instruction's `i_con_pcincr`: IDLE with `o_pc`=1, no `o_done`, no further `o_start`.
- **Watchdog.** `TIMEOUT_CYC`=64 and the core never responds.
  - `o_err`=1 exactly 64 WAIT cycles after `o_start`; block in IDLE.
  - Next `i_run` clears `o_err`.
- **Ignored strobes and reset.**
  - Load writes and `i_run` pulses while busy change neither memory nor pc.
  - `i_con_pcincr` during ISSUE is ignored.
  - `i_rst` in WAIT: next cycle all outputs 0 and memory still holds the program.
- **Wrap-around.** DEPTH=16, `i_last_addr`=15, `i_run` issued normally.
  - `o_pc` steps 0 through 15.
  - `o_done` after address 15.

Source files
------------

// File: rtl/bit_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_pkg
// Description : Shared types and constants for the bit-serial core's
//               instruction-issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
package bit_serial_pkg;

  localparam int INSTR_W             = 3;
  localparam int DEFAULT_DEPTH       = 16;
  localparam int DEFAULT_TIMEOUT_CYC = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    PAUSE = 2'd3
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_mem.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem
// Description : DEPTH x INSTR_W program store, synchronous write and
//               combinational read. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem
  import bit_serial_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  // Program words land on the rising edge; the array survives reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule
`default_nettype wire

// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : program_sequencer
// Description : Issues one stored instruction at a time to the bit-serial
//               core with a start strobe, advances on the core's PC-increment
//               strobe, and supports single-step, halt-at-boundary and a
//               completion watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module program_sequencer
  import bit_serial_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int AW          = $clog2(DEPTH),
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load_we,
  input  logic [AW-1:0]      i_load_addr,
  input  logic [INSTR_W-1:0] i_load_data,
  input  logic [AW-1:0]      i_last_addr,
  input  logic               i_run,
  input  logic               i_step_mode,
  input  logic               i_step,
  input  logic               i_halt,
  input  logic               i_con_pcincr,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_start,
  output logic [AW-1:0]      o_pc,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  // Counter wide enough to hold TIMEOUT_CYC itself.
  localparam int              WDOG_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDOG_W-1:0] TIMEOUT_CNT = WDOG_W'(TIMEOUT_CYC);

  seq_state_t          state_q, state_d;
  logic [AW-1:0]       pc_q, pc_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                halt_q, halt_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;

  logic                mem_we;
  logic [INSTR_W-1:0]  mem_rdata;
  logic [INSTR_W-1:0]  issue_instr;
  logic [WDOG_W-1:0]   wdog_inc;
  logic                halt_seen;

  assign mem_we    = (state_q == IDLE) && i_load_we;
  assign wdog_inc  = wdog_q + WDOG_W'(1);
  assign halt_seen = halt_q | i_halt;

  // The read port looks at the next pc so the instruction is captured on
  // the same edge that enters ISSUE.
  instr_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (i_load_addr),
    .i_wdata (i_load_data),
    .i_raddr (pc_d),
    .o_rdata (mem_rdata)
  );

  // A write and a run in the same IDLE cycle: forward the fresh word.
  assign issue_instr = (mem_we && (i_load_addr == pc_d)) ? i_load_data : mem_rdata;
  assign instr_d     = (state_d == ISSUE) ? issue_instr : instr_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      wdog_q  <= '0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wdog_q  <= wdog_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      instr_q <= instr_d;
    end
  end

  // Next-state logic: sequencing, halt flag, watchdog and completion.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wdog_d  = wdog_q;
    halt_d  = halt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_run) begin
          pc_d    = '0;
          err_d   = 1'b0;
          halt_d  = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        halt_d  = halt_seen;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_inc;
        halt_d = halt_seen;
        // Completion takes priority over a timeout landing on the same cycle.
        if (i_con_pcincr) begin
          halt_d = 1'b0;
          if (pc_q == i_last_addr) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            pc_d = pc_q + AW'(1);
            if (halt_seen) begin
              state_d = IDLE;
            end else if (i_step_mode) begin
              state_d = PAUSE;
            end else begin
              state_d = ISSUE;
            end
          end
        end else if (wdog_inc == TIMEOUT_CNT) begin
          err_d   = 1'b1;
          halt_d  = 1'b0;
          state_d = IDLE;
        end
      end
      PAUSE: begin
        if (i_step) begin
          state_d = ISSUE;
        end else if (i_halt) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    o_start = (state_q == ISSUE);
    o_busy  = (state_q != IDLE);
  end

  assign o_instr = instr_q;
  assign o_pc    = pc_q;
  assign o_done  = done_q;
  assign o_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_sequencer
// Description : Directed self-checking bench for program_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_we = 1'b0;
  logic [3:0] load_addr = '0;
  logic [2:0] load_data = '0;
  logic [3:0] last_addr = '0;
  logic       run = 1'b0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic       halt = 1'b0;
  logic       pcincr = 1'b0;
  logic [2:0] instr;
  logic       start;
  logic [3:0] pc;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  int         obs_cyc[$];
  logic [3:0] obs_pc[$];
  logic [2:0] obs_instr[$];
  int         done_cyc;
  int         err_cyc;
  int         end_cyc;
  logic       busy_at_done;

  program_sequencer #(
    .DEPTH       (16),
    .AW          (4),
    .TIMEOUT_CYC (64)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_load_we    (load_we),
    .i_load_addr  (load_addr),
    .i_load_data  (load_data),
    .i_last_addr  (last_addr),
    .i_run        (run),
    .i_step_mode  (step_mode),
    .i_step       (step),
    .i_halt       (halt),
    .i_con_pcincr (pcincr),
    .o_instr      (instr),
    .o_start      (start),
    .o_pc         (pc),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic load(input int a, input logic [2:0] d);
    load_we = 1'b1; load_addr = 4'(a); load_data = d;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic abort_run();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Core model: pulses i_run, then answers each o_start with i_con_pcincr
  // lat cycles later. Optional halt and busy-time disturbances.
  task automatic run_core(input int lat, input bit respond, input int halt_at,
                          input bit disturb, input int max_cyc);
    int cd;
    int first;
    obs_cyc.delete(); obs_pc.delete(); obs_instr.delete();
    done_cyc = -1; err_cyc = -1; end_cyc = -1; busy_at_done = 1'b1;
    cd = -1; first = -1;
    run = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      run = 1'b0; pcincr = 1'b0; halt = 1'b0; load_we = 1'b0;
      if (done && done_cyc < 0) begin done_cyc = c; busy_at_done = busy; end
      if (err && err_cyc < 0) err_cyc = c;
      if (start) begin
        obs_cyc.push_back(c); obs_pc.push_back(pc); obs_instr.push_back(instr);
        if (first < 0) first = c;
        cd = lat;
        if (disturb && obs_cyc.size() == 1) pcincr = 1'b1;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0 && respond) pcincr = 1'b1;
      end
      if (halt_at >= 0 && first >= 0 && c == first + halt_at) halt = 1'b1;
      if (disturb && first >= 0 && c == first + 2) begin
        load_we = 1'b1; load_addr = 4'd1; load_data = 3'd7; run = 1'b1;
      end
      if (obs_cyc.size() > 0 && !busy) begin end_cyc = c; break; end
    end
    run = 1'b0; pcincr = 1'b0; halt = 1'b0; load_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, start, done, err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, start, done, err});
    end
    checks++;
    if (pc !== 4'd0 || instr !== 3'd0) begin
      errors++; $display("FAIL reset_pc_instr: got pc %0d instr %0d expected 0 0", pc, instr);
    end
  endtask

  task automatic test_normal_run();
    logic [2:0] exp_i [3] = '{3'd1, 3'd4, 3'd2};
    load(0, 3'b001); load(1, 3'b100); load(2, 3'b010);
    last_addr = 4'd2;
    run_core(8, 1'b1, -1, 1'b0, 100);
    checks++;
    if (end_cyc < 0 || obs_cyc.size() != 3) begin
      errors++; $display("FAIL normal_starts: got %0d starts end %0d expected 3", obs_cyc.size(), end_cyc);
    end
    for (int i = 0; i < 3 && i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_instr[i] !== exp_i[i] || obs_pc[i] !== 4'(i)) begin
        errors++; $display("FAIL normal_issue%0d: got instr %0d pc %0d expected %0d %0d",
                           i, obs_instr[i], obs_pc[i], exp_i[i], i);
      end
    end
    if (obs_cyc.size() == 3) begin
      checks++;
      if (obs_cyc[1] - obs_cyc[0] != 9 || obs_cyc[2] - obs_cyc[1] != 9) begin
        errors++; $display("FAIL normal_spacing: got %0d %0d expected 9 9",
                           obs_cyc[1] - obs_cyc[0], obs_cyc[2] - obs_cyc[1]);
      end
      checks++;
      if (done_cyc != obs_cyc[2] + 9) begin
        errors++; $display("FAIL normal_done_time: got %0d expected %0d", done_cyc, obs_cyc[2] + 9);
      end
    end
    checks++;
    if (busy_at_done !== 1'b0) begin
      errors++; $display("FAIL normal_busy_at_done: got %b expected 0", busy_at_done);
    end
  endtask

  task automatic test_load_run_same_cycle();
    load_we = 1'b1; load_addr = 4'd0; load_data = 3'd6; run = 1'b1;
    @(negedge clk);
    load_we = 1'b0; run = 1'b0;
    checks++;
    if (start !== 1'b1 || instr !== 3'd6) begin
      errors++; $display("FAIL load_run_bypass: got start %b instr %0d expected 1 6", start, instr);
    end
    abort_run();
    load(0, 3'b001);
  endtask

  task automatic test_single_step();
    int n_start;
    step_mode = 1'b1; last_addr = 4'd2; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    checks++;
    if (start !== 1'b1) begin
      errors++; $display("FAIL step_first_start: got %b expected 1", start);
    end
    repeat (8) @(negedge clk);
    pcincr = 1'b1;
    @(negedge clk);
    pcincr = 1'b0;
    n_start = 0;
    for (int i = 0; i < 20; i++) begin
      if (start) n_start++;
      if (i < 19) @(negedge clk);
    end
    checks++;
    if (n_start != 0 || pc !== 4'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL step_pause: got starts %0d pc %0d busy %b expected 0 1 1", n_start, pc, busy);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    checks++;
    if (start !== 1'b1 || instr !== 3'd4 || pc !== 4'd1) begin
      errors++; $display("FAIL step_release: got start %b instr %0d pc %0d expected 1 4 1", start, instr, pc);
    end
    @(negedge clk);
    checks++;
    if (start !== 1'b0) begin
      errors++; $display("FAIL step_strobe_width: got %b expected 0", start);
    end
    step_mode = 1'b0;
    abort_run();
  endtask

  task automatic test_halt();
    int n_start;
    last_addr = 4'd2;
    run_core(8, 1'b1, 3, 1'b0, 100);
    checks++;
    if (obs_cyc.size() != 1 || end_cyc < 0 || end_cyc != obs_cyc[0] + 9) begin
      errors++; $display("FAIL halt_stop: got starts %0d end %0d expected 1 start, idle 9 after", obs_cyc.size(), end_cyc);
    end
    checks++;
    if (pc !== 4'd1 || done_cyc != -1) begin
      errors++; $display("FAIL halt_state: got pc %0d done_cyc %0d expected 1 -1", pc, done_cyc);
    end
    n_start = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (start || busy || done) n_start++;
    end
    checks++;
    if (n_start != 0) begin
      errors++; $display("FAIL halt_quiet: got %0d active cycles expected 0", n_start);
    end
  endtask

  task automatic test_watchdog();
    last_addr = 4'd2;
    run_core(0, 1'b0, -1, 1'b0, 200);
    checks++;
    if (obs_cyc.size() != 1 || err_cyc < 0 || err_cyc != obs_cyc[0] + 65) begin
      errors++; $display("FAIL wdog_time: got err_cyc %0d expected 65 after start", err_cyc);
    end
    checks++;
    if (busy !== 1'b0 || err !== 1'b1 || done_cyc != -1) begin
      errors++; $display("FAIL wdog_idle: got busy %b err %b done_cyc %0d expected 0 1 -1", busy, err, done_cyc);
    end
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    checks++;
    if (err !== 1'b0 || start !== 1'b1) begin
      errors++; $display("FAIL wdog_clear: got err %b start %b expected 0 1", err, start);
    end
    abort_run();
    // Completion arriving on the timeout cycle itself must win.
    last_addr = 4'd0;
    run_core(64, 1'b1, -1, 1'b0, 200);
    checks++;
    if (obs_cyc.size() != 1 || done_cyc != obs_cyc[0] + 65 || err_cyc != -1) begin
      errors++; $display("FAIL wdog_race: got done_cyc %0d err_cyc %0d expected done 65 after start, no err", done_cyc, err_cyc);
    end
  endtask

  task automatic test_ignored_strobes();
    logic [2:0] exp_i [3] = '{3'd1, 3'd4, 3'd2};
    last_addr = 4'd2;
    run_core(8, 1'b1, -1, 1'b1, 100);
    checks++;
    if (obs_cyc.size() != 3 || done_cyc < 0) begin
      errors++; $display("FAIL ignore_starts: got %0d starts done_cyc %0d expected 3 and done", obs_cyc.size(), done_cyc);
    end
    for (int i = 0; i < 3 && i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_instr[i] !== exp_i[i] || obs_pc[i] !== 4'(i) || obs_cyc[i] != obs_cyc[0] + 9 * i) begin
        errors++; $display("FAIL ignore_issue%0d: got instr %0d pc %0d at +%0d expected %0d %0d at +%0d",
                           i, obs_instr[i], obs_pc[i], obs_cyc[i] - obs_cyc[0], exp_i[i], i, 9 * i);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    logic [2:0] exp_i [3] = '{3'd1, 3'd4, 3'd2};
    last_addr = 4'd2; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, start, done, err} !== 4'b0000 || pc !== 4'd0 || instr !== 3'd0) begin
      errors++; $display("FAIL midreset_outputs: got flags %b pc %0d instr %0d expected 0000 0 0",
                         {busy, start, done, err}, pc, instr);
    end
    run_core(8, 1'b1, -1, 1'b0, 100);
    checks++;
    if (obs_cyc.size() != 3 || obs_instr[0] !== exp_i[0] || obs_instr[1] !== exp_i[1] || obs_instr[2] !== exp_i[2]) begin
      errors++; $display("FAIL midreset_memory: got %0d starts, program not 1 4 2", obs_cyc.size());
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) load(i, 3'(i));
    last_addr = 4'd15;
    run_core(2, 1'b1, -1, 1'b0, 200);
    checks++;
    if (obs_cyc.size() != 16) begin
      errors++; $display("FAIL wrap_count: got %0d starts expected 16", obs_cyc.size());
    end
    for (int i = 0; i < 16 && i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_pc[i] !== 4'(i) || obs_instr[i] !== 3'(i)) begin
        errors++; $display("FAIL wrap_issue%0d: got pc %0d instr %0d expected %0d %0d",
                           i, obs_pc[i], obs_instr[i], i, i % 8);
      end
    end
    if (obs_cyc.size() == 16) begin
      checks++;
      if (done_cyc != obs_cyc[15] + 3) begin
        errors++; $display("FAIL wrap_done: got %0d expected %0d", done_cyc, obs_cyc[15] + 3);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_normal_run();
    test_load_run_same_cycle();
    test_single_step();
    test_halt();
    test_watchdog();
    test_ignored_strobes();
    test_reset_in_wait();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
